// File: rtl/turn_request_ctrl.sv
// Turns raw left/right/hazard push buttons into steady L/R request levels for Lights.
// Each button is synchronized, debounced and edge-detected, then fed to a toggle-style request FSM.
module turn_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned TCNT_W          = 16,
    parameter int unsigned DCNT_W          = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnHaz,
    output logic       L,
    output logic       R,
    output logic [1:0] State
);

    localparam int unsigned NBTN = 3;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LEFT   = 2'b01,
        ST_RIGHT  = 2'b10,
        ST_HAZARD = 2'b11
    } state_t;

    logic [NBTN-1:0]   w_btn_raw;
    logic [NBTN-1:0]   r_sync1;
    logic [NBTN-1:0]   r_sync2;
    logic [NBTN-1:0]   r_deb;
    logic [NBTN-1:0]   r_deb_q;
    logic [DCNT_W-1:0] r_dcnt [NBTN];
    logic [NBTN-1:0]   w_press;
    logic              w_p_l;
    logic              w_p_r;
    logic              w_p_h;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_tcnt_nxt;
    logic              w_timeout;
    logic              r_l;
    logic              r_r;
    logic              w_l_nxt;
    logic              w_r_nxt;

    assign w_btn_raw = {BtnHaz, BtnR, BtnL};

    // Two-flop synchronizer, then a level is accepted only after DEBOUNCE_CYCLES disagreeing samples
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DCNT_LAST) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DCNT_W'(1);
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_q;
    assign w_p_l   = w_press[0];
    assign w_p_r   = w_press[1];
    assign w_p_h   = w_press[2];

    // State register; L/R are registered copies of the next-state decode
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
            r_l     <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_l     <= w_l_nxt;
            r_r     <= w_r_nxt;
        end
    end

    assign w_timeout = TIMEOUT_EN && (r_tcnt == TCNT_LAST);

    // Next state: hazard first, a simultaneous L+R press is a no-op, presses beat the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = '0;
        if (w_p_h) begin
            w_state_nxt = (r_state == ST_HAZARD) ? ST_IDLE : ST_HAZARD;
        end else if (!(w_p_l && w_p_r)) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_p_l)      w_state_nxt = ST_LEFT;
                    else if (w_p_r) w_state_nxt = ST_RIGHT;
                end
                ST_LEFT: begin
                    if (w_p_l)          w_state_nxt = ST_IDLE;
                    else if (w_p_r)     w_state_nxt = ST_RIGHT;
                    else if (w_timeout) w_state_nxt = ST_IDLE;
                end
                ST_RIGHT: begin
                    if (w_p_r)          w_state_nxt = ST_IDLE;
                    else if (w_p_l)     w_state_nxt = ST_LEFT;
                    else if (w_timeout) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
        if ((w_state_nxt == ST_LEFT) || (w_state_nxt == ST_RIGHT)) begin
            w_tcnt_nxt = (w_state_nxt == r_state) ? (r_tcnt + TCNT_W'(1)) : '0;
        end
    end

    // Output decode from the next state
    always_comb begin
        w_l_nxt = 1'b0;
        w_r_nxt = 1'b0;
        case (w_state_nxt)
            ST_LEFT:   w_l_nxt = 1'b1;
            ST_RIGHT:  w_r_nxt = 1'b1;
            ST_HAZARD: begin
                w_l_nxt = 1'b1;
                w_r_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign L     = r_l;
    assign R     = r_r;
    assign State = r_state;

endmodule

// File: tb/tb_turn_request_ctrl.sv
// Directed bench for turn_request_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
// Inputs change on the falling edge; {L,R,State} is checked on the falling edge.
module tb_turn_request_ctrl;

    localparam logic [3:0] S_IDLE  = 4'b0000;
    localparam logic [3:0] S_LEFT  = 4'b1001;
    localparam logic [3:0] S_RIGHT = 4'b0110;
    localparam logic [3:0] S_HAZ   = 4'b1111;

    logic       Clk;
    logic       Rst;
    logic       BtnL;
    logic       BtnR;
    logic       BtnHaz;
    logic       L;
    logic       R;
    logic [1:0] State;

    int n_assert = 0;
    int n_fail   = 0;

    turn_request_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16),
        .TCNT_W         (16),
        .DCNT_W         (8)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .BtnL  (BtnL),
        .BtnR  (BtnR),
        .BtnHaz(BtnHaz),
        .L     (L),
        .R     (R),
        .State (State)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        n_assert++;
        assert ({L, R, State} === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed L,R,State=%b expected=%b", tag, {L, R, State}, exp);
        end
    endtask

    initial begin
        Rst = 1'b0; BtnL = 1'b0; BtnR = 1'b0; BtnHaz = 1'b0;
        #100;
        // Reset with all buttons held high
        Rst = 1'b1; BtnL = 1'b1; BtnR = 1'b1; BtnHaz = 1'b1;
        #1 chk("reset_async", S_IDLE);
        cyc(4);
        chk("reset_held", S_IDLE);
        cyc(1);
        Rst = 1'b0;
        cyc(6);
        chk("post_reset_edge6", S_IDLE);
        cyc(1);
        chk("post_reset_hazard", S_HAZ);
        BtnL = 1'b0; BtnR = 1'b0; BtnHaz = 1'b0;
        cyc(12);
        chk("release_no_event", S_HAZ);
        BtnHaz = 1'b1;
        cyc(7);
        chk("hazard_off", S_IDLE);
        BtnHaz = 1'b0;
        cyc(12);

        // 8-cycle left pulse and 16-cycle timeout
        BtnL = 1'b1;
        cyc(6);
        chk("left_edge6", S_IDLE);
        cyc(1);
        chk("left_edge7", S_LEFT);
        cyc(1);
        BtnL = 1'b0;
        cyc(14);
        chk("left_last_cycle", S_LEFT);
        cyc(1);
        chk("left_timeout", S_IDLE);
        cyc(10);

        // Left then right 5 cycles later; timeout restarts at the switch
        BtnL = 1'b1;
        cyc(5);
        BtnR = 1'b1;
        cyc(2);
        chk("sw_left", S_LEFT);
        cyc(1);
        BtnL = 1'b0;
        cyc(3);
        chk("sw_before_switch", S_LEFT);
        cyc(1);
        chk("sw_right", S_RIGHT);
        cyc(1);
        BtnR = 1'b0;
        cyc(14);
        chk("sw_right_last", S_RIGHT);
        cyc(1);
        chk("sw_right_timeout", S_IDLE);
        cyc(10);

        // Hazard during LEFT, held long, L/R ignored, second hazard press exits
        BtnL = 1'b1;
        cyc(7);
        chk("haz_left", S_LEFT);
        cyc(1);
        BtnL = 1'b0;
        cyc(2);
        BtnHaz = 1'b1;
        cyc(6);
        chk("haz_still_left", S_LEFT);
        cyc(1);
        chk("haz_enter", S_HAZ);
        cyc(20);
        chk("haz_no_timeout", S_HAZ);
        BtnL = 1'b1;
        cyc(8);
        BtnL = 1'b0;
        cyc(10);
        chk("haz_ignore_l", S_HAZ);
        BtnR = 1'b1;
        cyc(8);
        BtnR = 1'b0;
        cyc(10);
        chk("haz_ignore_r", S_HAZ);
        cyc(44);
        chk("haz_held_100", S_HAZ);
        BtnHaz = 1'b0;
        cyc(10);
        chk("haz_release", S_HAZ);
        BtnHaz = 1'b1;
        cyc(6);
        chk("haz_exit_edge6", S_HAZ);
        cyc(1);
        chk("haz_exit", S_IDLE);
        cyc(1);
        BtnHaz = 1'b0;
        cyc(10);

        // 3-cycle glitch is rejected
        BtnL = 1'b1;
        cyc(3);
        BtnL = 1'b0;
        cyc(15);
        chk("glitch_short", S_IDLE);

        // 2-cycle low glitch during a held press gives no second press
        BtnL = 1'b1;
        cyc(7);
        chk("held_left", S_LEFT);
        cyc(3);
        BtnL = 1'b0;
        cyc(2);
        BtnL = 1'b1;
        cyc(8);
        chk("low_glitch", S_LEFT);
        BtnL = 1'b0;
        cyc(2);
        chk("low_glitch_last", S_LEFT);
        cyc(1);
        chk("low_glitch_timeout", S_IDLE);
        cyc(10);

        // Simultaneous L and R from IDLE
        BtnL = 1'b1; BtnR = 1'b1;
        cyc(7);
        chk("both_edge7", S_IDLE);
        cyc(1);
        BtnL = 1'b0; BtnR = 1'b0;
        cyc(10);
        chk("both_after", S_IDLE);

        // Right toggled off by a second right press, ahead of its timeout
        BtnR = 1'b1;
        cyc(7);
        chk("right_on", S_RIGHT);
        cyc(1);
        BtnR = 1'b0;
        cyc(6);
        BtnR = 1'b1;
        cyc(6);
        chk("right_before_toggle", S_RIGHT);
        cyc(1);
        chk("right_toggle_off", S_IDLE);
        cyc(1);
        BtnR = 1'b0;
        cyc(10);

        // Asynchronous reset mid-LEFT
        BtnL = 1'b1;
        cyc(7);
        chk("rst_left", S_LEFT);
        cyc(1);
        BtnL = 1'b0;
        cyc(3);
        #2 Rst = 1'b1;
        #1 chk("rst_mid_left_async", S_IDLE);
        cyc(1);
        chk("rst_mid_left_held", S_IDLE);
        cyc(2);
        Rst = 1'b0;
        cyc(10);
        chk("rst_after", S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_request_ctrl.md
Name: turn_request_ctrl

Overview:
- Upstream stage of the Lights sequencer. Turns raw push-button inputs (left, right, hazard) into the steady L/R request levels that Lights consumes.
- Synchronizes and debounces each button and converts presses into toggle-style requests.
- Auto-cancels a turn request after a programmable timeout.
- Drives L=1,R=1 for hazard, matching the Lights both-active mode.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a button level change; minimum 1.
- TIMEOUT_CYCLES, 1024, number of cycles a LEFT/RIGHT request stays active before auto-cancel; 0 disables the timeout.
- TCNT_W, 16, timeout counter width; must satisfy 2^TCNT_W > TIMEOUT_CYCLES.
- DCNT_W, 8, debounce counter width; must satisfy 2^DCNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- BtnL  input  1  raw left button, asynchronous, active-high.
- BtnR  input  1  raw right button, asynchronous, active-high.
- BtnHaz  input  1  raw hazard button, asynchronous, active-high.
- L  output  1  left request to Lights, registered.
- R  output  1  right request to Lights, registered.
- State  output  2  debug view of FSM: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

Behaviour:
- Reset (Rst=1, async): all synchronizer flops, debounced levels, debounce and timeout counters = 0; FSM = IDLE; L=0, R=0, State=00. Reset mid-request drops L/R immediately, without waiting for a clock edge.
- Synchronizer: two flops per button; s = second flop output.
- Debounce, per button:
  - Hold deb (debounced level) and cnt.
  - If s==deb: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: deb<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is rejected.
- Press detect: press = deb & ~deb_q (deb_q = deb delayed one cycle). One cycle wide per accepted rising level. Releases generate no events.
- Latency: raw rising input stable before edge 1 -> L/R/State change at edge DEBOUNCE_CYCLES+3.
- FSM, evaluated on each edge. Priority is pH > simultaneous pL&pR > single press.
  - Hazard press (pH) in any state: IDLE/LEFT/RIGHT -> HAZARD; HAZARD -> IDLE.
  - pL and pR together, without pH: no state change.
  - IDLE: pL -> LEFT; pR -> RIGHT.
  - LEFT: pL -> IDLE; pR -> RIGHT; timeout -> IDLE.
  - RIGHT: pR -> IDLE; pL -> LEFT; timeout -> RIGHT exits to IDLE.
  - HAZARD: pL/pR ignored; no timeout.
- Timeout counter:
  - Cleared to 0 on every transition into LEFT or RIGHT, including a direct LEFT<->RIGHT switch.
  - Increments each cycle while in LEFT or RIGHT.
  - When it equals TIMEOUT_CYCLES-1 and no press occurs that cycle, FSM -> IDLE. L (or R) is therefore high for exactly TIMEOUT_CYCLES cycles.
  - A press in the same cycle as the timeout wins.
  - Held at 0 in IDLE/HAZARD.
  - TIMEOUT_CYCLES=0: no auto-cancel.
- Outputs registered, decoded from next state:
  - IDLE: L=0, R=0.
  - LEFT: L=1, R=0.
  - RIGHT: L=0, R=1.
  - HAZARD: L=1, R=1.
- Held buttons: a continuously held button produces exactly one press; it must be released (debounced low) before the next press.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
- Reset: Rst=1 with all buttons high at 100 ns, release at 150 ns -> L=0, R=0, State=00 during reset. A press is accepted only after deb follows low->high again; since the buttons are still high, deb rises once, giving one press (State=11 via hazard).
- BtnL pulse 8 cycles -> L=1, R=0, State=01 at edge 7. L falls after exactly 16 cycles high; State=00.
- BtnL press, then BtnR press 5 cycles later -> State 01 -> 10. R stays high 16 cycles from the switch edge, not from the first press.
- BtnHaz press during LEFT -> L=1, R=1, State=11. Hold for 100 cycles with no timeout; BtnL/BtnR presses are ignored. A second BtnHaz press -> 00.
- Glitch rejection: BtnL high for 3 cycles, then low -> no change, L=0. Also a 2-cycle low glitch during a held press -> no second press event.
- Simultaneous BtnL and BtnR pressed on the same cycle from IDLE -> State stays 00. Assert Rst asynchronously mid-LEFT -> L=0 immediately, State=00.
